// File: rtl/wbvgaarbiter.sv
// Two-master Wishbone arbiter: video frame reader (A) and CPU/DMA (B) share one slave bus.
// Define VGAARB_FAIRNESS_EN to alternate grants on contention; otherwise A has strict priority.

module wbvgaarbiter #(
  parameter int unsigned AW        = 24,
  parameter int unsigned DW        = 32,
  parameter int unsigned LGTIMEOUT = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // Master A (video)
  input  logic              i_a_cyc,
  input  logic              i_a_stb,
  input  logic              i_a_we,
  input  logic [AW-1:0]     i_a_addr,
  input  logic [DW-1:0]     i_a_data,
  input  logic [DW/8-1:0]   i_a_sel,
  output logic              o_a_ack,
  output logic              o_a_stall,
  output logic              o_a_err,
  // Master B (CPU/DMA)
  input  logic              i_b_cyc,
  input  logic              i_b_stb,
  input  logic              i_b_we,
  input  logic [AW-1:0]     i_b_addr,
  input  logic [DW-1:0]     i_b_data,
  input  logic [DW/8-1:0]   i_b_sel,
  output logic              o_b_ack,
  output logic              o_b_stall,
  output logic              o_b_err,
  output logic [DW-1:0]     o_rd_data,
  // Slave side
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [DW-1:0]     o_wb_data,
  output logic [DW/8-1:0]   o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic              i_wb_err,
  input  logic [DW-1:0]     i_wb_data,
  // Status
  output logic [1:0]        o_owner,
  output logic              o_timeout
);

  // Encoding doubles as the o_owner code.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwnA = 2'b01,
    StOwnB = 2'b10
  } state_e;

  localparam logic [LGTIMEOUT:0] TimeLimit = {1'b1, {LGTIMEOUT{1'b0}}};
  localparam logic [LGTIMEOUT:0] TimerOne  = {{LGTIMEOUT{1'b0}}, 1'b1};

  state_e             state_q, state_d, pick;
  logic               abort_q, abort_d;
  logic [LGTIMEOUT:0] timer_q, timer_d;
  logic               decide;
  logic               own_cyc, own_stb, own_a, own_b;
  logic               wb_cyc, timeout;

`ifdef VGAARB_FAIRNESS_EN
  logic last_b_q, last_b_d;
`endif

  // Arbitration choice from the current requests.
  always_comb begin
    pick = StIdle;
    if (i_a_cyc && i_b_cyc) begin
`ifdef VGAARB_FAIRNESS_EN
      pick = last_b_q ? StOwnA : StOwnB;
`else
      pick = StOwnA;
`endif
    end else if (i_a_cyc) begin
      pick = StOwnA;
    end else if (i_b_cyc) begin
      pick = StOwnB;
    end
  end

  // Slave-side multiplexer; everything reads zero with no owner.
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_data = '0;
    o_wb_sel  = '0;
    unique case (state_q)
      StOwnA: begin
        own_cyc   = i_a_cyc;
        own_stb   = i_a_stb;
        o_wb_we   = i_a_we;
        o_wb_addr = i_a_addr;
        o_wb_data = i_a_data;
        o_wb_sel  = i_a_sel;
      end
      StOwnB: begin
        own_cyc   = i_b_cyc;
        own_stb   = i_b_stb;
        o_wb_we   = i_b_we;
        o_wb_addr = i_b_addr;
        o_wb_data = i_b_data;
        o_wb_sel  = i_b_sel;
      end
      default: ;
    endcase
  end

  assign wb_cyc   = own_cyc && !abort_q;
  assign o_wb_cyc = wb_cyc;
  assign o_wb_stb = own_stb && !abort_q;

  // A response in the limit cycle wins over the timeout.
  assign timeout   = wb_cyc && !i_wb_ack && !i_wb_err && (timer_q == TimeLimit);
  assign o_timeout = timeout;

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    decide  = 1'b0;
    unique case (state_q)
      StOwnA:  decide = !i_a_cyc;
      StOwnB:  decide = !i_b_cyc;
      default: decide = 1'b1;
    endcase

    if (decide) begin
      state_d = pick;
      abort_d = 1'b0;
    end else if (timeout) begin
      abort_d = 1'b1;
    end

    if (!wb_cyc || i_wb_ack || i_wb_err || timeout) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TimerOne;
    end
  end

`ifdef VGAARB_FAIRNESS_EN
  always_comb begin
    last_b_d = last_b_q;
    if (decide && (pick != StIdle)) begin
      last_b_d = (pick == StOwnB);
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      abort_q  <= 1'b0;
      timer_q  <= '0;
`ifdef VGAARB_FAIRNESS_EN
      last_b_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      abort_q  <= abort_d;
      timer_q  <= timer_d;
`ifdef VGAARB_FAIRNESS_EN
      last_b_q <= last_b_d;
`endif
    end
  end

  // Master-side returns.
  assign own_a = (state_q == StOwnA);
  assign own_b = (state_q == StOwnB);

  assign o_a_ack   = own_a && !abort_q && i_wb_ack;
  assign o_a_err   = own_a && !abort_q && (i_wb_err || timeout);
  assign o_a_stall = !own_a || (i_wb_stall && !abort_q);

  assign o_b_ack   = own_b && !abort_q && i_wb_ack;
  assign o_b_err   = own_b && !abort_q && (i_wb_err || timeout);
  assign o_b_stall = !own_b || (i_wb_stall && !abort_q);

  assign o_rd_data = i_wb_data;
  assign o_owner   = state_q;

endmodule

// File: tb/tb_wbvgaarbiter.sv
// Self-checking bench for wbvgaarbiter: randomized transfers checked against a grant-order model.
// Honours VGAARB_FAIRNESS_EN to select the expected arbitration policy.

module tb_wbvgaarbiter;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned LG = 10;
  localparam int Limit = 1 << LG;
  localparam int VW = 3 + AW + DW + DW / 8;

`ifdef VGAARB_FAIRNESS_EN
  localparam bit Fair = 1'b1;
`else
  localparam bit Fair = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0]     a_addr, b_addr;
  logic [DW-1:0]     a_data, b_data;
  logic [DW/8-1:0]   a_sel, b_sel;
  logic              o_a_ack, o_a_stall, o_a_err, o_b_ack, o_b_stall, o_b_err;
  logic [DW-1:0]     o_rd_data;
  logic              o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0]     o_wb_addr;
  logic [DW-1:0]     o_wb_data;
  logic [DW/8-1:0]   o_wb_sel;
  logic              i_wb_ack, i_wb_stall, i_wb_err;
  logic [DW-1:0]     i_wb_data;
  logic [1:0]        o_owner;
  logic              o_timeout;

  int n_chk = 0;
  int n_fail = 0;
  int model_last_b = 1;  // last granted master per the model (1 = B)

  wbvgaarbiter #(.AW(AW), .DW(DW), .LGTIMEOUT(LG)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
    .i_a_data(a_data), .i_a_sel(a_sel),
    .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
    .i_b_data(b_data), .i_b_sel(b_sel),
    .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
    .o_rd_data(o_rd_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data),
    .o_owner(o_owner), .o_timeout(o_timeout)
  );

  function automatic logic [1:0] own_code(input int m);
    return (m != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic ack_of(input int m);
    return (m != 0) ? o_b_ack : o_a_ack;
  endfunction

  function automatic logic err_of(input int m);
    return (m != 0) ? o_b_err : o_a_err;
  endfunction

  function automatic logic stall_of(input int m);
    return (m != 0) ? o_b_stall : o_a_stall;
  endfunction

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] dat,
                         input logic [DW/8-1:0] sel);
    if (m == 0) begin
      a_cyc = cyc; a_stb = stb; a_we = we; a_addr = addr; a_data = dat; a_sel = sel;
    end else begin
      b_cyc = cyc; b_stb = stb; b_we = we; b_addr = addr; b_data = dat; b_sel = sel;
    end
  endtask

  task automatic idle_all;
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_err = 1'b0; i_wb_data = '0;
  endtask

  task automatic test_reset;
    logic [11:0] got, want;
    logic [AW+DW+DW/8-1:0] bus;
    idle_all();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    got  = {o_owner, o_wb_cyc, o_wb_stb, o_wb_we, o_a_ack, o_a_err, o_a_stall,
            o_b_ack, o_b_err, o_b_stall, o_timeout};
    want = 12'b0000_0001_0010;
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", got, want);
    end
    bus = {o_wb_addr, o_wb_data, o_wb_sel};
    n_chk++;
    if (bus !== '0) begin
      n_fail++;
      $display("FAIL reset_bus_zero: got %h want 0", bus);
    end
    model_last_b = 1;
  endtask

  task automatic test_single(input int iters);
    for (int it = 0; it < iters; it++) begin
      int m   = (it == 0) ? 0 : int'($urandom_range(1, 0));
      int lat = (it == 0) ? 0 : int'($urandom_range(3, 0));
      logic [AW-1:0] ad = (it == 0) ? AW'(24'h000100) : AW'($urandom);
      logic [DW-1:0] dt = DW'($urandom);
      logic [DW-1:0] rd = DW'($urandom);
      logic [DW/8-1:0] sl = (DW/8)'($urandom);
      logic we = 1'($urandom);
      logic [VW-1:0] got, want;
      step();
      drive_m(m, 1'b1, 1'b1, we, ad, dt, sl);
      @(negedge clk);
      n_chk++;
      if (o_owner !== 2'b00 || stall_of(m) !== 1'b1 || o_wb_cyc !== 1'b0) begin
        n_fail++;
        $display("FAIL single_wait: owner %b stall %b cyc %b, want 00 1 0",
                 o_owner, stall_of(m), o_wb_cyc);
      end
      step();
      @(negedge clk);
      n_chk++;
      if (o_owner !== own_code(m) || stall_of(m) !== 1'b0) begin
        n_fail++;
        $display("FAIL single_grant: owner %b stall %b, want %b 0",
                 o_owner, stall_of(m), own_code(m));
      end
      got  = {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel};
      want = {1'b1, 1'b1, we, ad, dt, sl};
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL single_route: got %h want %h", got, want);
      end
      model_last_b = m;
      step();
      drive_m(m, 1'b1, 1'b0, we, ad, dt, sl);
      for (int k = 0; k < lat; k++) begin
        step();
      end
      i_wb_ack  = 1'b1;
      i_wb_data = rd;
      @(negedge clk);
      n_chk++;
      if (ack_of(m) !== 1'b1 || ack_of(1 - m) !== 1'b0 || o_rd_data !== rd) begin
        n_fail++;
        $display("FAIL single_ack: ack %b other %b data %h, want 1 0 %h",
                 ack_of(m), ack_of(1 - m), o_rd_data, rd);
      end
      step();
      i_wb_ack = 1'b0;
      drive_m(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      n_chk++;
      if (o_wb_cyc !== 1'b0) begin
        n_fail++;
        $display("FAIL single_release: wb_cyc %b want 0", o_wb_cyc);
      end
      step();
      @(negedge clk);
      n_chk++;
      if (o_owner !== 2'b00) begin
        n_fail++;
        $display("FAIL single_idle: owner %b want 00", o_owner);
      end
    end
  endtask

  task automatic test_contest(input int iters);
    for (int it = 0; it < iters; it++) begin
      logic [AW-1:0] ad [2];
      int w, l;
      ad[0] = AW'($urandom);
      ad[1] = AW'($urandom);
      w = Fair ? ((model_last_b != 0) ? 0 : 1) : 0;
      l = 1 - w;
      step();
      drive_m(0, 1'b1, 1'b1, 1'b0, ad[0], '0, '1);
      drive_m(1, 1'b1, 1'b1, 1'b0, ad[1], '0, '1);
      step();
      @(negedge clk);
      n_chk++;
      if (o_owner !== own_code(w) || stall_of(l) !== 1'b1 || o_wb_addr !== ad[w]) begin
        n_fail++;
        $display("FAIL contest_grant: owner %b loser_stall %b addr %h, want %b 1 %h",
                 o_owner, stall_of(l), o_wb_addr, own_code(w), ad[w]);
      end
      model_last_b = w;
      step();
      drive_m(w, 1'b1, 1'b0, 1'b0, ad[w], '0, '1);
      i_wb_ack = 1'b1;
      @(negedge clk);
      n_chk++;
      if (ack_of(w) !== 1'b1 || ack_of(l) !== 1'b0) begin
        n_fail++;
        $display("FAIL contest_ack: winner %b loser %b, want 1 0", ack_of(w), ack_of(l));
      end
      step();
      i_wb_ack = 1'b0;
      drive_m(w, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      n_chk++;
      if (o_wb_cyc !== 1'b0) begin
        n_fail++;
        $display("FAIL contest_gap: wb_cyc %b want 0", o_wb_cyc);
      end
      step();
      @(negedge clk);
      n_chk++;
      if (o_owner !== own_code(l) || o_wb_cyc !== 1'b1 || o_wb_addr !== ad[l]) begin
        n_fail++;
        $display("FAIL contest_handover: owner %b cyc %b addr %h, want %b 1 %h",
                 o_owner, o_wb_cyc, o_wb_addr, own_code(l), ad[l]);
      end
      model_last_b = l;
      step();
      drive_m(l, 1'b1, 1'b0, 1'b0, ad[l], '0, '1);
      i_wb_ack = 1'b1;
      step();
      i_wb_ack = 1'b0;
      drive_m(l, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      step();
    end
  endtask

  task automatic test_timeout(input int m);
    int o = 1 - m;
    int fired = -1;
    int nerr = 0;
    logic [AW-1:0] ad = AW'($urandom);
    logic [AW-1:0] ad2 = AW'($urandom);
    logic [5:0] got;
    step();
    drive_m(m, 1'b1, 1'b1, 1'b0, ad, '0, '1);
    for (int k = 0; k <= Limit; k++) begin
      step();
      if (k == 1) drive_m(m, 1'b1, 1'b0, 1'b0, ad, '0, '1);
      @(negedge clk);
      if (o_timeout === 1'b1 && fired < 0) fired = k;
      if (err_of(m) === 1'b1) nerr++;
    end
    model_last_b = m;
    n_chk++;
    if (fired !== Limit) begin
      n_fail++;
      $display("FAIL timeout_cycle: fired at %0d want %0d", fired, Limit);
    end
    n_chk++;
    if (nerr !== 1) begin
      n_fail++;
      $display("FAIL timeout_err_count: got %0d want 1", nerr);
    end
    step();
    i_wb_ack = 1'b1;
    drive_m(o, 1'b1, 1'b1, 1'b0, ad2, '0, '1);
    @(negedge clk);
    got = {o_wb_cyc, o_wb_stb, ack_of(m), err_of(m), o_timeout, stall_of(o)};
    n_chk++;
    if (got !== 6'b000001 || o_owner !== own_code(m)) begin
      n_fail++;
      $display("FAIL abort_hold: got %b owner %b, want 000001 %b", got, o_owner, own_code(m));
    end
    step();
    i_wb_ack = 1'b0;
    drive_m(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    n_chk++;
    if (o_wb_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_release: wb_cyc %b want 0", o_wb_cyc);
    end
    step();
    @(negedge clk);
    n_chk++;
    if (o_owner !== own_code(o) || o_wb_cyc !== 1'b1 || o_wb_addr !== ad2) begin
      n_fail++;
      $display("FAIL abort_handover: owner %b cyc %b addr %h, want %b 1 %h",
               o_owner, o_wb_cyc, o_wb_addr, own_code(o), ad2);
    end
    model_last_b = o;
    step();
    drive_m(o, 1'b1, 1'b0, 1'b0, ad2, '0, '1);
    i_wb_ack = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ack_of(o) !== 1'b1) begin
      n_fail++;
      $display("FAIL post_abort_ack: got %b want 1", ack_of(o));
    end
    step();
    i_wb_ack = 1'b0;
    drive_m(o, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
  endtask

  task automatic test_ack_at_limit(input int m);
    int fired = -1;
    int nerr = 0;
    logic got_ack = 1'b0;
    logic [AW-1:0] ad = AW'($urandom);
    step();
    drive_m(m, 1'b1, 1'b1, 1'b0, ad, '0, '1);
    for (int k = 0; k <= Limit; k++) begin
      step();
      if (k == 1) drive_m(m, 1'b1, 1'b0, 1'b0, ad, '0, '1);
      if (k == Limit) i_wb_ack = 1'b1;
      @(negedge clk);
      if (o_timeout === 1'b1 && fired < 0) fired = k;
      if (err_of(m) === 1'b1) nerr++;
      if (k == Limit) got_ack = ack_of(m);
    end
    model_last_b = m;
    n_chk++;
    if (fired !== -1 || nerr !== 0) begin
      n_fail++;
      $display("FAIL limit_no_timeout: fired %0d errs %0d, want -1 0", fired, nerr);
    end
    n_chk++;
    if (got_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_ack: got %b want 1", got_ack);
    end
    step();
    i_wb_ack = 1'b0;
    drive_m(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
  endtask

  task automatic test_back_to_back;
    int exp_q[$];
    int pend [2];
    int lb, w;
    idle_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_last_b = 1;
    pend[0] = 4;
    pend[1] = 4;
    lb = model_last_b;
    while (pend[0] > 0 || pend[1] > 0) begin
      if (pend[0] > 0 && pend[1] > 0) w = Fair ? ((lb != 0) ? 0 : 1) : 0;
      else w = (pend[0] > 0) ? 0 : 1;
      exp_q.push_back(w);
      lb = w;
      pend[w]--;
    end
    pend[0] = 4;
    pend[1] = 4;
    for (int r = 0; r < exp_q.size(); r++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        if (pend[m] > 0) drive_m(m, 1'b1, 1'b1, 1'b0, AW'($urandom), '0, '1);
        else drive_m(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
      step();
      @(negedge clk);
      n_chk++;
      if (o_owner !== own_code(exp_q[r])) begin
        n_fail++;
        $display("FAIL b2b_grant_%0d: owner %b want %b", r, o_owner, own_code(exp_q[r]));
      end
      if (o_owner === 2'b01) w = 0;
      else if (o_owner === 2'b10) w = 1;
      else w = exp_q[r];
      if (pend[w] > 0) pend[w]--;
      model_last_b = w;
      step();
      drive_m(1 - w, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive_m(w, 1'b1, 1'b0, 1'b0, o_wb_addr, '0, '1);
      i_wb_ack = 1'b1;
      step();
      i_wb_ack = 1'b0;
      drive_m(w, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    end
    step();
  endtask

  task automatic test_reset_mid(input int m);
    logic [AW-1:0] ad = AW'($urandom);
    step();
    drive_m(m, 1'b1, 1'b1, 1'b0, ad, '0, '1);
    step();
    @(negedge clk);
    n_chk++;
    if (o_wb_cyc !== 1'b1 || o_owner !== own_code(m)) begin
      n_fail++;
      $display("FAIL midreset_pre: cyc %b owner %b, want 1 %b", o_wb_cyc, o_owner, own_code(m));
    end
    step();
    drive_m(m, 1'b1, 1'b0, 1'b0, ad, '0, '1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_wb_ack = 1'b1;
    @(negedge clk);
    n_chk++;
    if (o_owner !== 2'b00 || o_wb_cyc !== 1'b0 || ack_of(m) !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_post: owner %b cyc %b ack %b, want 00 0 0",
               o_owner, o_wb_cyc, ack_of(m));
    end
    model_last_b = 1;
    step();
    i_wb_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (o_owner !== own_code(m)) begin
      n_fail++;
      $display("FAIL midreset_regrant: owner %b want %b", o_owner, own_code(m));
    end
    model_last_b = m;
    step();
    drive_m(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
  endtask

  initial begin
    test_reset();
    test_single(6);
    test_contest(3);
    test_timeout(1);
    test_ack_at_limit(1);
    test_back_to_back();
    test_reset_mid(int'($urandom_range(1, 0)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wbvgaarbiter.md
# wbvgaarbiter

Two-master Wishbone arbiter that shares one memory bus between the VGA frame reader (master A, the frame-buffer fetch port of the frame engine) and a CPU/DMA port (master B). It sits between the frame engine's `o_wb_*` port and the memory slave. It grants whole bus cycles, gives video priority by default, and aborts any cycle the slave fails to answer within a bounded time.

## Interface
- `AW`, 24: Wishbone word-address width.
- `DW`, 32: Wishbone data width.
- `LGTIMEOUT`, 10: log2 of the no-response abort limit, in cycles.

Ports:
- `i_clk`  in  1: single system clock; every register updates on its rising edge.
- `i_reset`  in  1: synchronous, active-high reset.
- `i_a_cyc`, `i_a_stb`, `i_a_we`  in  1 each: video master bus-cycle, strobe and write-enable controls.
- `i_a_addr`  in  AW: video master address.
- `i_a_data`  in  DW: video master write data.
- `i_a_sel`  in  DW/8: video master byte selects.
- `o_a_ack`, `o_a_stall`, `o_a_err`  out  1 each: video master acknowledge, stall and error returns.
- `i_b_cyc`, `i_b_stb`, `i_b_we`, `i_b_addr`, `i_b_data`, `i_b_sel`  in: CPU master requests, same widths as master A.
- `o_b_ack`, `o_b_stall`, `o_b_err`  out  1 each: CPU master returns.
- `o_rd_data`  out  DW: `i_wb_data`, passed through to both masters.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each: slave-side bus-cycle, strobe and write-enable.
- `o_wb_addr`  out  AW: slave-side address.
- `o_wb_data`  out  DW: slave-side write data.
- `o_wb_sel`  out  DW/8: slave-side byte selects.
- `i_wb_ack`, `i_wb_stall`, `i_wb_err`  in  1 each: slave acknowledge, stall and error.
- `i_wb_data`  in  DW: slave read data.
- `o_owner`  out  2: current grant; 00 = none, 01 = A, 10 = B.
- `o_timeout`  out  1: one-cycle pulse when a cycle is aborted.

## Operation
- State machine, registered:
  - IDLE: nothing granted.
  - OWN_A: master A holds the bus.
  - OWN_B: master B holds the bus.
- Decision rule, applied in IDLE and on the release cycle of an owner:
  - If only one `cyc` is asserted, grant that master.
  - If both are asserted, grant A. The fairness option below changes this.
  - If neither is asserted, go to IDLE.
- Release: the owner drops its `cyc`. On that same cycle the decision rule picks the next state, so a waiting master is handed the bus directly with no extra IDLE cycle.
- Slave-side outputs:
  - `o_wb_cyc` = owner `cyc` and not `abort`.
  - `o_wb_stb` = owner `stb` and not `abort`.
  - `we`/`addr`/`data`/`sel` are multiplexed from the owner. They read as zero when no master is granted.
- Master-side returns:
  - The non-owner sees `stall`=1, `ack`=0, `err`=0.
  - The owner sees `i_wb_stall`, `i_wb_ack` and `i_wb_err`, each gated by not `abort`.
- Timeout:
  - Counter of width LGTIMEOUT+1 increments on each cycle with `o_wb_cyc` high and neither `i_wb_ack` nor `i_wb_err` asserted.
  - It clears on any ack, on any err, or when `o_wb_cyc` is low.
  - On reaching 2^LGTIMEOUT: pulse `o_timeout`, assert one-cycle `err` to the owner, and set `abort`.
- Abort:
  - `abort` holds until the owner drops `cyc`.
  - While it holds, slave-side `cyc`/`stb` are low and late acks are discarded.
  - `abort` clears on the release cycle.
- Masters must drop `cyc` when they have no outstanding requests. An idle held `cyc` times out.

## Timing
- Reset state:
  - State IDLE, counter 0, `abort` 0.
  - `o_owner`=00, `o_timeout`=0.
  - All slave-side outputs 0; all acks and errs 0; both stalls 1.
- Grant latency: a master raising `cyc` from IDLE is granted one clock later. `o_wb_cyc` rises in that granted cycle, and the master sees stall until then.
- Handover: if the owner's `cyc` falls in cycle n, the new owner drives `o_wb_cyc` in cycle n+1. `o_wb_cyc` is always low for at least cycle n.
- Ack and timeout limit in the same cycle: the ack wins. The counter clears and no abort occurs.
- Slave err: passed through to the owner unchanged. No abort.
- Reset mid-cycle: the cycle after `i_reset`, state is IDLE and `o_wb_cyc` is 0. In-flight acks are dropped.
- All returns are combinational from the `i_wb_*` signals and the registered state. There are no extra pipeline stages.

## Configuration
- `VGAARB_FAIRNESS_EN` defined:
  - A 1-bit `last_owner` register is updated at each grant.
  - When both masters request at a decision, the grant goes to the master that was not `last_owner`, so the two alternate.
  - `last_owner` resets to B, so A wins the first contest.
- Not defined: strict A priority. B can starve while A keeps re-requesting.

## Test plan
- Reset, then A raises `cyc`+`stb` to address 0x000100 with a 1-cycle-latency slave. Required:
  - `o_owner`=01 one cycle later.
  - `o_wb_addr`=0x000100.
  - `o_a_ack` asserted one cycle after the strobe is accepted.
- A and B raise `cyc` in the same cycle. Required:
  - A is granted; B sees stall=1.
  - A drops `cyc` at cycle n; `o_owner`=10 at n+1.
- The slave never acks a B read. Required:
  - After 1024 cycles: `o_timeout` pulse, one `o_b_err`, `o_wb_cyc`=0.
  - A late `i_wb_ack` is not forwarded.
  - When B drops `cyc`, A can be granted.
- Ack arrives exactly on cycle 1024. Required: no `o_timeout`, and `o_b_ack` is delivered.
- With `VGAARB_FAIRNESS_EN` defined, A and B each issue 4 back-to-back single-word cycles, both continuously requesting. Required: grants alternate A, B, A, B… Without the macro: A, A, A, A, then B.
- `i_reset` asserted mid-burst while `o_wb_cyc`=1. Required: next cycle `o_owner`=00 and `o_wb_cyc`=0.
